// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Pipeline stage register with stall, flush, valid/ready handshake
//            and a saturating stall counter. Define PIPE_STAGE_SKID_EN to add
//            a one-entry skid buffer and a registered in_ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CTRL_W-1:0] w_ctrl_in;

  // A bubble must never carry live control bits downstream.
  assign w_ctrl_in = in_valid ? in_ctrl : '0;

`ifdef PIPE_STAGE_SKID_EN
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              w_adv;
  logic              w_acc;

  // An empty main register may advance even under stall (bubble collapse).
  assign w_adv    = ~stall | ~r_valid;
  assign w_acc    = in_valid & in_ready;
  assign in_ready = ~r_skid_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_ctrl       <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_adv) begin
      if (r_skid_valid) begin
        r_valid      <= 1'b1;
        r_data       <= r_skid_data;
        r_ctrl       <= r_skid_ctrl;
        r_skid_valid <= 1'b0;
      end else begin
        r_valid <= in_valid;
        r_data  <= in_data;
        r_ctrl  <= w_ctrl_in;
      end
    end else if (w_acc) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
      r_skid_ctrl  <= in_ctrl;
    end
  end
`else
  assign in_ready = ~stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (!stall) begin
      r_valid <= in_valid;
      r_data  <= in_data;
      r_ctrl  <= w_ctrl_in;
    end
  end
`endif

  // Clear wins over a simultaneous increment; count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (clr_cnt) begin
      r_stall_cnt <= '0;
    end else if (stall && r_valid && !flush && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ctrl  = r_ctrl;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

- Parametrised pipeline stage register: the general successor to the fixed per-stage flip-flop blocks.
- Carries a DATA_W payload plus a CTRL_W control-bit vector (e.g. we_mem, re_mem, wb_sel) between two pipeline stages.
- Supports stall, flush/bubble insertion and a valid/ready handshake, with an optional one-entry skid buffer.
- Also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- DATA_W, 16, payload width (alu result, address, store data)
- CTRL_W, 3, control-bit width; every control bit is forced to 0 in a bubble
- CNT_W, 8, stall counter width

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hazard-unit hold request for this stage
- flush  in  1  kill the stage contents (branch mispredict / exception)
- in_valid  in  1  upstream stage holds a real instruction
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- in_ready  out  1  stage can accept in_data this cycle
- out_valid  out  1  registered valid
- out_data  out  DATA_W  registered payload
- out_ctrl  out  CTRL_W  registered control bits, 0 whenever out_valid=0
- clr_cnt  in  1  clear stall counter
- stall_cnt  out  CNT_W  saturating count of stalled-while-valid cycles

## Operation
- Main register: valid_q, data_q, ctrl_q drive out_valid, out_data, out_ctrl directly. No combinational path from the inputs to these outputs.
- Input acceptance: acc = in_valid & in_ready.
- Priority per edge: rst_n=0, then flush, then stall/hold, then load.
- Reset (rst_n=0 at edge):
  - valid_q, data_q, ctrl_q, skid state and stall_cnt all go to 0.
- Flush:
  - valid_q and ctrl_q go to 0, and skid_valid goes to 0.
  - data_q holds its value.
  - Any input accepted in the same cycle is discarded.
- Base mode (macro undefined):
  - in_ready = ~stall (combinational).
  - When stall=1, all state holds, including when valid_q=0.
  - When stall=0:
    - valid_q takes in_valid and data_q takes in_data.
    - ctrl_q takes in_valid ? in_ctrl : 0, so a bubble never carries live control bits.
- Stall counter:
  - Increments on each edge where stall=1 & valid_q=1 & flush=0.
  - Saturates at 2^CNT_W-1.
  - clr_cnt=1 clears it and wins over a simultaneous increment.
- Width rules:
  - Payload and control bits are passed bit-exact, with no arithmetic on them.
  - The counter is unsigned, CNT_W bits.

## Timing
- Latency: 1 cycle from an accepted input to out_*.
- Throughput: 1 transfer per cycle while stall=0.
- A stall asserted in cycle N holds out_* stable through cycle N+1.
- flush in cycle N gives out_valid=0 and out_ctrl=0 in cycle N+1, regardless of stall.
- Stall together with flush: flush wins and the stage becomes empty.
- stall_cnt reflects an increment 1 cycle after the qualifying cycle.
- Reset while stalled or mid-skid: all state is cleared; nothing is retained or replayed.

## Configuration
- Macro: PIPE_STAGE_SKID_EN.
- Undefined: base mode as above. in_ready is combinational from stall.
- Defined: adds a one-entry skid buffer (skid_valid, skid_data, skid_ctrl).
  - in_ready = ~skid_valid; it is registered, so there is no combinational stall-to-ready path.
  - Reset value of in_ready is 1.
  - Advance condition: adv = ~stall | ~valid_q, so a stall does not block an empty stage (bubble collapse).
  - When adv=1 and skid_valid=1: main register loads the skid contents and skid_valid goes to 0.
  - When adv=1 and skid_valid=0: main register loads the input using the base-mode rule.
  - When adv=0 and acc=1: the skid buffer captures in_data/in_ctrl and skid_valid goes to 1.
  - No data is lost or duplicated. The maximum number of in-flight entries is 2.
- The stall counter, flush and reset behaviour are identical in both builds.

## Test plan
- Reset then idle:
  - Stimulus: rst_n=0 for 2 cycles, then stall=0, in_valid=0.
  - Required: out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0. in_ready=1 (skid build) or 1 (base build, because stall=0).
- Streaming:
  - Stimulus: in_data=16'h1234/16'h5678/16'h9ABC on consecutive cycles, in_ctrl=3'b101, stall=0.
  - Required: out_data shows the same sequence 1 cycle later; out_ctrl=3'b101 each cycle.
- Stall hold:
  - Stimulus: load 16'hBEEF with ctrl 3'b010, then stall=1 for 3 cycles.
  - Required: out_data=16'hBEEF and out_ctrl=3'b010 held; stall_cnt=3.
  - Skid build only: one in-flight input (16'hCAFE) is held in skid and appears at out_data on the first cycle after the stall drops.
- Flush priority:
  - Stimulus: flush=1 together with stall=1 and in_valid=1 (in_ctrl=3'b111).
  - Required: the next cycle has out_valid=0 and out_ctrl=3'b000; the skid buffer is emptied and in_ready=1.
- Bubble control:
  - Stimulus: in_valid=0 with in_ctrl=3'b111, stall=0.
  - Required: out_valid=0 and out_ctrl=3'b000.
- Counter saturation:
  - Setup: CNT_W=4.
  - Stimulus: stall=1 with valid_q=1 for 20 cycles.
  - Required: stall_cnt=4'hF.
  - Then: clr_cnt=1 with stall=1 gives stall_cnt=0 on the next cycle.
